// File: rtl/rv_data_mem_bytes.sv
// RV32I data memory: byte/half/word access, load extension,
// fault checking and a fixed-latency response pipeline.
module rv_data_mem_bytes #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dmem_req_i,
  input  logic                 dmem_wr_i,
  input  logic [31:0]          dmem_addr_i,
  input  logic [1:0]           dmem_size_i,
  input  logic                 dmem_zero_ext_i,
  input  logic [31:0]          dmem_wr_data_i,
  output logic                 dmem_rsp_valid_o,
  output logic [31:0]          dmem_rsp_data_o,
  output logic                 dmem_rsp_err_o,
  output logic [ERR_CNT_W-1:0] dmem_err_cnt_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]          mem_q [DEPTH_WORDS];
  logic                 vld_q [RD_LATENCY];
  logic [31:0]          dat_q [RD_LATENCY];
  logic                 err_q [RD_LATENCY];
  logic [ERR_CNT_W-1:0] cnt_q;

  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic          fault;
  logic          acc;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   dat_d;

  assign idx  = dmem_addr_i[AW+1:2];
  assign word = mem_q[idx];
  assign lh   = dmem_addr_i[1] ? word[31:16] : word[15:0];
  assign acc  = dmem_req_i && !reset;
  assign we   = acc && dmem_wr_i && !fault;

  // Decode faults, lane enables, store data and the extended load value.
  always_comb begin
    fault = 1'b0;
    be    = 4'b0000;
    wd    = dmem_wr_data_i;
    dat_d = 32'h0;
    lb    = word[8*dmem_addr_i[1:0] +: 8];
    if (dmem_addr_i[31:AW+2] != '0) fault = 1'b1;
    case (dmem_size_i)
      2'b00: begin
        be    = 4'b0001 << dmem_addr_i[1:0];
        wd    = {4{dmem_wr_data_i[7:0]}};
        dat_d = dmem_zero_ext_i ? {24'h0, lb}
                                : {{24{lb[7]}}, lb};
      end
      2'b01: begin
        if (dmem_addr_i[0]) fault = 1'b1;
        be    = dmem_addr_i[1] ? 4'b1100 : 4'b0011;
        wd    = {2{dmem_wr_data_i[15:0]}};
        dat_d = dmem_zero_ext_i ? {16'h0, lh}
                                : {{16{lh[15]}}, lh};
      end
      2'b10: begin
        if (dmem_addr_i[1:0] != 2'b00) fault = 1'b1;
        be    = 4'b1111;
        dat_d = word;
      end
      default: fault = 1'b1;
    endcase
    if (fault || dmem_wr_i) dat_d = 32'h0;
  end

  // Byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
    end
  end

  // Response pipeline; idle slots carry zero data and error.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= 32'h0;
        err_q[i] <= 1'b0;
      end
    end else begin
      vld_q[0] <= dmem_req_i;
      dat_q[0] <= dmem_req_i ? dat_d : 32'h0;
      err_q[0] <= dmem_req_i && fault;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
        err_q[i] <= err_q[i-1];
      end
    end
  end

  // Saturating count of faulted requests.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (acc && fault && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end

  assign dmem_rsp_valid_o = vld_q[RD_LATENCY-1];
  assign dmem_rsp_data_o  = dat_q[RD_LATENCY-1];
  assign dmem_rsp_err_o   = err_q[RD_LATENCY-1];
  assign dmem_err_cnt_o   = cnt_q;

endmodule

// File: tb/tb_rv_data_mem_bytes.sv
// Directed bench for rv_data_mem_bytes: three instances
// (latency 1, 2 and 3) share one stimulus stream.
module tb_rv_data_mem_bytes;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr, zx;
  logic [31:0] addr, wdat;
  logic [1:0]  size;

  logic        v1, v2, v3;
  logic [31:0] d1, d2, d3;
  logic        e1, e2, e3;
  logic [7:0]  c1, c2;
  logic [1:0]  c3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rv_data_mem_bytes #(.DEPTH_WORDS(1024), .RD_LATENCY(1),
                      .ERR_CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .dmem_req_i(req), .dmem_wr_i(wr),
    .dmem_addr_i(addr), .dmem_size_i(size),
    .dmem_zero_ext_i(zx), .dmem_wr_data_i(wdat),
    .dmem_rsp_valid_o(v1), .dmem_rsp_data_o(d1),
    .dmem_rsp_err_o(e1), .dmem_err_cnt_o(c1));

  rv_data_mem_bytes #(.DEPTH_WORDS(1024), .RD_LATENCY(2),
                      .ERR_CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .dmem_req_i(req), .dmem_wr_i(wr),
    .dmem_addr_i(addr), .dmem_size_i(size),
    .dmem_zero_ext_i(zx), .dmem_wr_data_i(wdat),
    .dmem_rsp_valid_o(v2), .dmem_rsp_data_o(d2),
    .dmem_rsp_err_o(e2), .dmem_err_cnt_o(c2));

  rv_data_mem_bytes #(.DEPTH_WORDS(1024), .RD_LATENCY(3),
                      .ERR_CNT_W(2)) u3 (
    .clk(clk), .reset(reset), .dmem_req_i(req), .dmem_wr_i(wr),
    .dmem_addr_i(addr), .dmem_size_i(size),
    .dmem_zero_ext_i(zx), .dmem_wr_data_i(wdat),
    .dmem_rsp_valid_o(v3), .dmem_rsp_data_o(d3),
    .dmem_rsp_err_o(e3), .dmem_err_cnt_o(c3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic r, input logic w,
                     input logic [31:0] a, input logic [1:0] s,
                     input logic z, input logic [31:0] d);
    req = r; wr = w; addr = a; size = s; zx = z; wdat = d;
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv(1, 1, 32'h0, 2'b10, 0, 32'hFFFFFFFF);
    tick(); tick();
    n_cmp++;
    if ({v1, v2, v3, e1, e2, e3} !== 6'b0 ||
        {d1, d2, d3} !== 96'h0) begin
      n_bad++;
      $display("FAIL reset_rsp: v=%b%b%b d1=%h want all 0",
               v1, v2, v3, d1);
    end
    n_cmp++;
    if (c1 !== 8'd0 || c3 !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: c1=%0d c3=%0d want 0", c1, c3);
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_load_ext();
    logic [31:0] exp [3];
    exp[0] = 32'hFFFFFF88;
    exp[1] = 32'h00000088;
    exp[2] = 32'hFFFF8899;
    drv(1, 1, 32'h0, 2'b10, 0, 32'h8899AABB);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drv(1, 0, 32'h3, 2'b00, 0, 0);
      if (i == 1) drv(1, 0, 32'h3, 2'b00, 1, 0);
      if (i == 2) drv(1, 0, 32'h2, 2'b01, 0, 0);
      tick();
      n_cmp++;
      if (v1 !== 1'b1 || d1 !== exp[i] || e1 !== 1'b0) begin
        n_bad++;
        $display("FAIL load_ext%0d: v=%b d=%h e=%b want 1 %h 0",
                 i, v1, d1, e1, exp[i]);
      end
    end
    idle(1);
    n_cmp++;
    if (v1 !== 1'b0 || d1 !== 32'h0 || e1 !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_zero: v=%b d=%h e=%b want 0", v1, d1, e1);
    end
  endtask

  task automatic test_store_merge();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drv(1, 1, 32'h10, 2'b10, 0, 32'h11223344);
      if (i == 1) drv(1, 1, 32'h11, 2'b00, 0, 32'hFFFFFFEE);
      if (i == 2) drv(1, 1, 32'h12, 2'b01, 0, 32'hFFFFBEEF);
      tick();
      n_cmp++;
      if (v1 !== 1'b1 || d1 !== 32'h0 || e1 !== 1'b0) begin
        n_bad++;
        $display("FAIL store_rsp%0d: v=%b d=%h e=%b want 1 0 0",
                 i, v1, d1, e1);
      end
    end
    drv(1, 0, 32'h10, 2'b10, 0, 0);
    tick();
    n_cmp++;
    if (v1 !== 1'b1 || d1 !== 32'hBEEFEE44 || e1 !== 1'b0) begin
      n_bad++;
      $display("FAIL store_merge: v=%b d=%h e=%b want 1 beefee44 0",
               v1, d1, e1);
    end
    idle(3);
  endtask

  task automatic test_faults();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drv(1, 0, 32'h6, 2'b10, 0, 0);
      if (i == 1) drv(1, 1, 32'h1, 2'b01, 0, 32'h0000FFFF);
      if (i == 2) drv(1, 1, 32'h0, 2'b11, 0, 32'h0);
      if (i == 3) drv(1, 0, 32'h1000, 2'b10, 0, 0);
      if (i == 4) drv(1, 1, 32'h1000, 2'b10, 0, 32'h0);
      tick();
      n_cmp++;
      if (v1 !== 1'b1 || e1 !== 1'b1 || d1 !== 32'h0) begin
        n_bad++;
        $display("FAIL fault%0d: v=%b e=%b d=%h want 1 1 0",
                 i, v1, e1, d1);
      end
      if (i == 3) begin
        n_cmp++;
        if (c1 !== 8'd4) begin
          n_bad++;
          $display("FAIL err_cnt4: got %0d want 4", c1);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      drv(1, 0, 32'h8, 2'b11, 0, 0);
      tick();
    end
    n_cmp++;
    if (c1 !== 8'd10) begin
      n_bad++;
      $display("FAIL err_cnt10: got %0d want 10", c1);
    end
    n_cmp++;
    if (c3 !== 2'd3) begin
      n_bad++;
      $display("FAIL err_cnt_sat: got %0d want 3", c3);
    end
    drv(1, 0, 32'h0, 2'b10, 0, 0);
    tick();
    n_cmp++;
    if (v1 !== 1'b1 || d1 !== 32'h8899AABB || e1 !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_nowrite: v=%b d=%h e=%b want 1 8899aabb 0",
               v1, d1, e1);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drv(1, 1, 32'(4 * i), 2'b10, 0, 32'(i));
      tick();
    end
    idle(3);
    for (int i = 0; i < 11; i++) begin
      if (i < 8) drv(1, 0, 32'(4 * i), 2'b10, 0, 0);
      else drv(0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if (i >= 2 && i < 10) begin
        if (v3 !== 1'b1 || d3 !== 32'(i - 2) || e3 !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b%0d: v=%b d=%h want 1 %h",
                   i, v3, d3, 32'(i - 2));
        end
      end else if (v3 !== 1'b0 || d3 !== 32'h0) begin
        n_bad++;
        $display("FAIL b2b_idle%0d: v=%b d=%h want 0 0", i, v3, d3);
      end
    end
  endtask

  task automatic test_ordering();
    logic [31:0] exp [3];
    exp[0] = 32'hCAFE0001;
    exp[1] = 32'h0;
    exp[2] = 32'h5;
    drv(1, 1, 32'h40, 2'b10, 0, 32'hCAFE0001);
    tick();
    idle(3);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drv(1, 0, 32'h40, 2'b10, 0, 0);
      if (i == 1) drv(1, 1, 32'h40, 2'b10, 0, 32'h5);
      if (i == 2) drv(1, 0, 32'h40, 2'b10, 0, 0);
      if (i >= 3) drv(0, 0, 0, 0, 0, 0);
      tick();
      if (i >= 1 && i <= 3) begin
        n_cmp++;
        if (v2 !== 1'b1 || d2 !== exp[i-1]) begin
          n_bad++;
          $display("FAIL order%0d: v=%b d=%h want 1 %h",
                   i - 1, v2, d2, exp[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_flush();
    drv(1, 1, 32'h20, 2'b10, 0, 32'h12345678);
    tick();
    idle(3);
    drv(1, 0, 32'h20, 2'b10, 0, 0);
    tick();
    tick();
    reset = 1'b1;
    drv(1, 1, 32'h20, 2'b10, 0, 32'hDEADDEAD);
    tick();
    reset = 1'b0;
    n_cmp++;
    if (v3 !== 1'b0 || v1 !== 1'b0 || c1 !== 8'd0 || c3 !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_flush: v3=%b v1=%b c1=%0d c3=%0d want 0",
               v3, v1, c1, c3);
    end
    drv(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (v3 !== 1'b0 || v2 !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_drop%0d: v3=%b v2=%b want 0", i, v3, v2);
      end
    end
    drv(1, 0, 32'h20, 2'b10, 0, 0);
    tick();
    n_cmp++;
    if (v1 !== 1'b1 || d1 !== 32'h12345678) begin
      n_bad++;
      $display("FAIL rst_mem1: v=%b d=%h want 1 12345678", v1, d1);
    end
    drv(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    n_cmp++;
    if (v3 !== 1'b1 || d3 !== 32'h12345678 || e3 !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mem3: v=%b d=%h want 1 12345678", v3, d3);
    end
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    test_reset();
    test_load_ext();
    test_store_merge();
    test_faults();
    test_back_to_back();
    test_ordering();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
